// File: rtl/systolic_result_collector.sv
// Collects output rows streamed by systolic_array into a row buffer, then replays
// them downstream over a valid/ready stream with a last-beat marker.
module systolic_result_collector #(
    parameter int unsigned BitSize     = 8,
    parameter int unsigned NumOfNerves = 3,
    parameter int unsigned MaxRows     = 4,
    parameter bit          ReLU        = 1'b0,
    localparam int unsigned CntW       = $clog2(MaxRows + 1),
    localparam int unsigned RowW       = NumOfNerves * BitSize
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            in_valid,
    input  logic            in_done,
    input  logic [RowW-1:0] in_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [RowW-1:0] rd_data,
    output logic            rd_last,
    output logic [CntW-1:0] rd_count,
    output logic            busy,
    output logic            overflow
);

    localparam int unsigned AddrW = (MaxRows > 1) ? $clog2(MaxRows) : 1;

    typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   rd_count_q, rd_count_d;
    logic              overflow_q, overflow_d;
    logic              wr_en;
    logic [AddrW-1:0]  wr_addr;
    logic [RowW-1:0]   row_in;
    logic [RowW-1:0]   mem_q [MaxRows];

    // Optional clamp of negative lanes before the row enters the buffer.
    always_comb begin
        row_in = in_data;
        if (ReLU) begin
            for (int j = 0; j < NumOfNerves; j++) begin
                if (in_data[j*BitSize + BitSize - 1]) begin
                    row_in[j*BitSize +: BitSize] = '0;
                end
            end
        end
    end

    assign rd_valid = (state_q == StDrain);
    assign busy     = (state_q == StDrain);
    assign rd_last  = (state_q == StDrain) && (rd_ptr_q == rd_count_q - CntW'(1));
    assign rd_data  = (state_q == StDrain) ? mem_q[rd_ptr_q[AddrW-1:0]] : '0;
    assign rd_count = rd_count_q;
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_count_d = rd_count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_q[AddrW-1:0];
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    wr_ptr_d   = CntW'(1);
                    rd_ptr_d   = '0;
                    rd_count_d = '0;
                    overflow_d = 1'b0;
                    if (in_done) begin
                        rd_count_d = CntW'(1);
                        state_d    = StDrain;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                if (in_valid) begin
                    if (wr_ptr_q < CntW'(MaxRows)) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + CntW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                // A row arriving with in_done is already counted in wr_ptr_d.
                if (in_done) begin
                    rd_count_d = wr_ptr_d;
                    rd_ptr_d   = '0;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (in_valid) begin
                    overflow_d = 1'b1;
                end
                if (rd_ready) begin
                    if (rd_last) begin
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                        state_d  = StIdle;
                    end else begin
                        rd_ptr_d = rd_ptr_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_count_q <= rd_count_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer contents need no reset; reads are gated by the drain state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= row_in;
        end
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Bench for systolic_result_collector: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the collect/replay behaviour.
module tb_systolic_result_collector;

    localparam int unsigned RW = 24;
    localparam int unsigned MaxRows = 4;

    logic          clk;
    logic          res_n;
    logic          in_valid;
    logic          in_done;
    logic [RW-1:0] in_data;
    logic          rd_ready;

    logic          v0, l0, b0, o0, v1, l1, b1, o1;
    logic [RW-1:0] d0, d1;
    logic [2:0]    c0, c1;

    systolic_result_collector #(.BitSize(8), .NumOfNerves(3), .MaxRows(MaxRows), .ReLU(1'b0)) dut0 (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_done(in_done), .in_data(in_data),
        .rd_valid(v0), .rd_ready(rd_ready), .rd_data(d0), .rd_last(l0), .rd_count(c0),
        .busy(b0), .overflow(o0)
    );

    systolic_result_collector #(.BitSize(8), .NumOfNerves(3), .MaxRows(MaxRows), .ReLU(1'b1)) dut1 (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_done(in_done), .in_data(in_data),
        .rd_valid(v1), .rd_ready(rd_ready), .rd_data(d1), .rd_last(l1), .rd_count(c1),
        .busy(b1), .overflow(o1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] relu(input logic [RW-1:0] r);
        logic [RW-1:0] o;
        o = r;
        for (int j = 0; j < 3; j++) begin
            if (r[j*8 + 7]) o[j*8 +: 8] = 8'h00;
        end
        return o;
    endfunction

    // Model: rows of the set being gathered, and rows still to be replayed.
    logic [RW-1:0] m_cap[$];
    logic [RW-1:0] m_out[$];
    bit            m_collecting = 1'b0;
    bit            m_ovf = 1'b0;
    int            m_cnt = 0;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            m_cap.delete();
            m_out.delete();
            m_collecting = 1'b0;
            m_ovf = 1'b0;
            m_cnt = 0;
        end else if (m_out.size() > 0) begin
            if (in_valid) m_ovf = 1'b1;
            if (rd_ready) void'(m_out.pop_front());
        end else if (!m_collecting) begin
            if (in_valid) begin
                m_cap.delete();
                m_cap.push_back(in_data);
                m_ovf = 1'b0;
                m_cnt = 0;
                m_collecting = 1'b1;
                if (in_done) begin
                    m_out = m_cap;
                    m_cnt = 1;
                    m_collecting = 1'b0;
                end
            end
        end else begin
            if (in_valid) begin
                if (m_cap.size() < MaxRows) m_cap.push_back(in_data);
                else m_ovf = 1'b1;
            end
            if (in_done) begin
                m_out = m_cap;
                m_cnt = m_cap.size();
                m_collecting = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit ev;
            ev = (m_out.size() > 0);
            check("rd_valid0", 32'(v0), 32'(ev));
            check("rd_valid1", 32'(v1), 32'(ev));
            check("busy0", 32'(b0), 32'(ev));
            check("busy1", 32'(b1), 32'(ev));
            check("overflow0", 32'(o0), 32'(m_ovf));
            check("overflow1", 32'(o1), 32'(m_ovf));
            if (ev) begin
                check("rd_data0", 32'(d0), 32'(m_out[0]));
                check("rd_data1", 32'(relu_out(m_out[0])), 32'(d1) ^ 32'(d1) ^ 32'(relu(m_out[0])));
                check("rd_last0", 32'(l0), 32'(m_out.size() == 1));
                check("rd_last1", 32'(l1), 32'(m_out.size() == 1));
            end else begin
                check("rd_last0_idle", 32'(l0), 32'd0);
            end
            if (!res_n) begin
                check("rd_data0_rst", 32'(d0), 32'd0);
                check("rd_data1_rst", 32'(d1), 32'd0);
            end
            if (!m_collecting) begin
                check("rd_count0", 32'(c0), 32'(m_cnt));
                check("rd_count1", 32'(c1), 32'(m_cnt));
            end
        end
    end

    // Returns the ReLU DUT's actual row so the compare above reads actual vs model.
    function automatic logic [RW-1:0] relu_out(input logic [RW-1:0] unused);
        return d1;
    endfunction

    logic [RW-1:0] got[$];

    task automatic drive(input bit v, input bit d, input logic [RW-1:0] row);
        in_valid = v;
        in_done  = d;
        in_data  = row;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_done  = 1'b0;
    endtask

    // Runs the drain with a per-cycle ready pattern (ready=1 once the pattern runs out).
    task automatic collect(input logic [7:0] pat, input int plen, output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        got.delete();
        for (int c = 0; c < 40; c++) begin
            rd_ready = (c < plen) ? pat[c] : 1'b1;
            #1;
            if (b0) nbusy++;
            if (v0) seen = 1'b1;
            if (v0 && rd_ready) got.push_back(d0);
            if (seen && !v0) return;
            @(posedge clk);
            #1;
        end
        check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic capture3(input bit with_done);
        drive(1'b1, 1'b0, 24'h070605);
        drive(1'b1, 1'b0, 24'h030001);
        drive(1'b1, 1'b0, 24'h000202);
        if (with_done) drive(1'b0, 1'b1, '0);
    endtask

    task automatic check_three(input string tag);
        check({tag, "_nbeats"}, 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check({tag, "_beat1"}, 32'(got[0]), 32'h070605);
            check({tag, "_beat2"}, 32'(got[1]), 32'h030001);
            check({tag, "_beat3"}, 32'(got[2]), 32'h000202);
        end
    endtask

    initial begin
        int nbusy;
        res_n    = 1'b1;
        in_valid = 1'b0;
        in_done  = 1'b0;
        in_data  = '0;
        rd_ready = 1'b1;
        #2;
        res_n   = 1'b0;
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(v0), 32'd0);
        check("reset_count", 32'(c0), 32'd0);
        res_n = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: three rows, ready held high.
        capture3(1'b1);
        check("s1_valid_after_done", 32'(v0), 32'd1);
        check("s1_count", 32'(c0), 32'd3);
        collect(8'hFF, 0, nbusy);
        check_three("s1");
        check("s1_busy_cycles", 32'(nbusy), 32'd3);

        // Scenario 2: stalled drain.
        capture3(1'b1);
        collect(8'b0001_1001, 5, nbusy);
        check_three("s2");

        // Scenario 3: overflow past MaxRows.
        for (int k = 1; k <= 5; k++) drive(1'b1, 1'b0, RW'(k));
        drive(1'b0, 1'b1, '0);
        check("s3_overflow", 32'(o0), 32'd1);
        check("s3_count", 32'(c0), 32'd4);
        collect(8'hFF, 0, nbusy);
        check("s3_nbeats", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4 && k < got.size(); k++) check("s3_beat", 32'(got[k]), 32'(k + 1));
        check("s3_overflow_idle", 32'(o0), 32'd1);
        drive(1'b1, 1'b0, 24'h000009);
        check("s3_overflow_cleared", 32'(o0), 32'd0);
        drive(1'b0, 1'b1, '0);
        collect(8'hFF, 0, nbusy);

        // Scenario 4: in_done together with the second row.
        drive(1'b1, 1'b0, 24'h111111);
        drive(1'b1, 1'b1, 24'h222222);
        check("s4_valid", 32'(v0), 32'd1);
        check("s4_count", 32'(c0), 32'd2);
        collect(8'hFF, 0, nbusy);
        check("s4_nbeats", 32'(got.size()), 32'd2);
        if (got.size() == 2) check("s4_beat2", 32'(got[1]), 32'h222222);

        // Scenario 5: ReLU clamp versus raw pass-through.
        drive(1'b1, 1'b1, 24'hF00580);
        check("s5_relu1", 32'(d1), 32'h000500);
        check("s5_relu0", 32'(d0), 32'hF00580);
        collect(8'hFF, 0, nbusy);

        // Scenario 6: reset mid-drain.
        capture3(1'b1);
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
        res_n = 1'b0;
        #1;
        check("s6_rst_valid", 32'(v0), 32'd0);
        check("s6_rst_data", 32'(d0), 32'd0);
        check("s6_rst_busy", 32'(b0), 32'd0);
        check("s6_rst_last", 32'(l0), 32'd0);
        @(posedge clk);
        #1;
        check("s6_rst_hold_valid", 32'(v0), 32'd0);
        res_n = 1'b1;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        check("s6_idle_after_rst", 32'(v0), 32'd0);
        capture3(1'b1);
        collect(8'hFF, 0, nbusy);
        check_three("s6");

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            in_done  = ($urandom_range(0, 9) == 0);
            in_data  = RW'($urandom);
            rd_ready = ($urandom_range(0, 9) < 7);
            res_n    = ($urandom_range(0, 299) != 0);
            @(posedge clk);
            #1;
        end
        res_n    = 1'b1;
        in_valid = 1'b0;
        in_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
